// File: rtl/branch_pkg.sv
// branch_pkg: shared defaults, opcode encodings and FSM states for branch_ctrl.
package branch_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int OFF_W       = 8;

    typedef enum logic [3:0] {
        OP_JMP     = 4'hA,
        OP_BZ      = 4'hB,
        OP_BNZ     = 4'hC,
        OP_LOOPSET = 4'hD,
        OP_LOOPEND = 4'hE
    } opcode_e;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_e;

endpackage

// File: rtl/loop_counter.sv
// loop_counter: hardware loop iteration counter. Load has priority over
// decrement; decrement saturates at zero.
module loop_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         nonzero
);

    // Count register: reload on LOOPSET, step down on a taken LOOPEND.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && nonzero)
            count <= count - W'(1);
    end

    assign nonzero = |count;

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: decodes the ROM word for the current PC, drives PCSrc/immediate
// into pc and squashes the single wrong-path fetch after a taken branch.
// Optional hardware loop counter is built when BRANCH_LOOP_EN is defined;
// otherwise LOOPSET/LOOPEND behave as not-taken NOPs.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    output logic [PC_W-1:0]    immediate,
    output logic               PCSrc,
    output logic               squash
);

    state_e          state, state_nx;
    logic [3:0]      opcode;
    logic [PC_W-1:0] off;
    logic            take;
    logic            unused_bits;

    assign opcode      = instr[15:12];
    assign unused_bits = ^instr[11:8];
    // Offset is signed and relative to the branch itself.
    assign off         = PC_W'($signed(instr[OFF_W-1:0]));

`ifdef BRANCH_LOOP_EN
    logic             cnt_load, cnt_dec, cnt_nonzero;
    logic [OFF_W-1:0] loop_count_unused;

    // Counter only moves on a RUN cycle; squashed words leave it alone.
    assign cnt_load = (state == RUN) && (opcode == OP_LOOPSET);
    assign cnt_dec  = (state == RUN) && (opcode == OP_LOOPEND) && cnt_nonzero;

    loop_counter #(.W(OFF_W)) u_loop_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (instr[OFF_W-1:0]),
        .count    (loop_count_unused),
        .nonzero  (cnt_nonzero)
    );
`endif

    // Raw taken decision for the current word, before FSM gating.
    always_comb begin
        take = 1'b0;
        case (opcode)
            OP_JMP:     take = 1'b1;
            OP_BZ:      take = zero;
            OP_BNZ:     take = !zero;
`ifdef BRANCH_LOOP_EN
            OP_LOOPEND: take = cnt_nonzero;
`endif
            default:    take = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= FILL;
        else
            state <= state_nx;
    end

    // Next state and outputs; only RUN may redirect the PC.
    always_comb begin
        state_nx = state;
        PCSrc    = 1'b0;
        squash   = 1'b1;
        case (state)
            FILL:   state_nx = RUN;
            RUN: begin
                squash = 1'b0;
                if (take) begin
                    PCSrc    = 1'b1;
                    state_nx = SQUASH;
                end
            end
            SQUASH: state_nx = RUN;
            default: state_nx = FILL;
        endcase
        // pc already holds branch+1, so pull one back off the offset.
        immediate = PCSrc ? (off - PC_W'(1)) : '0;
    end

endmodule
